// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control / debug front end for the cpu.
// Debounces the pause and step buttons, runs the RUN/HALT/STEPP control FSM
// that drives the cpu PAUSE/STEP inputs, handles a one-shot PC breakpoint, and
// records data-memory writes in a small overwrite-oldest trace FIFO.
//
// Trace read handshake: the head entry is valid whenever TRACE_EMPTY is low
// (first-word fall-through on TRACE_ADDR/TRACE_DATA). A TRACE_POP seen while
// TRACE_EMPTY is low consumes the head at that clock edge. A TRACE_POP while
// empty is ignored. The writer side (cpuout_memupdate) is never back-pressured.
// When the FIFO is full, a push without a pop drops the oldest entry instead.
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter int DEB_CYCLES  = 250000,
  parameter int DEB_W       = 18,
  parameter int TRACE_DEPTH = 8,
  parameter int TRACE_AW    = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                BTN_PAUSE,
  input  logic                BTN_STEP,
  input  logic                BRK_EN,
  input  logic [7:0]          BRK_PC,
  input  logic [7:0]          cpuout_PC,
  input  logic                cpuout_memupdate,
  input  logic [7:0]          cpuout_memaddr,
  input  logic [15:0]         cpuout_memdata,
  input  logic                TRACE_POP,
  output logic                PAUSE,
  output logic                STEP,
  output logic                BRK_HIT,
  output logic                TRACE_EMPTY,
  output logic [7:0]          TRACE_ADDR,
  output logic [15:0]         TRACE_DATA,
  output logic                TRACE_OVF,
  output logic [1:0]          o_dbg_state,
  output logic [TRACE_AW:0]   o_dbg_trace_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_STEPP = 2'd2
  } state_t;

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TRACE_AW:0] CNT_FULL = (TRACE_AW + 1)'(TRACE_DEPTH);

  // ---------------------------------------------------------------------------
  // Button conditioning. Index 0 = pause button, index 1 = step button.
  // ---------------------------------------------------------------------------
  logic [1:0]            w_btn_raw;
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_deb;
  logic [1:0]            r_press;
  logic [1:0][DEB_W-1:0] r_deb_cnt;
  logic                  w_pause_press;
  logic                  w_step_press;

  assign w_btn_raw = {BTN_STEP, BTN_PAUSE};

  // Two-flop synchroniser, then a debouncer that flips the level once the
  // synced input has disagreed with it for DEB_CYCLES consecutive samples.
  // The press strobe is raised in the same edge that the level rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      r_press   <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb_cnt[i] <= '0;
          r_deb[i]     <= r_sync2[i];
          r_press[i]   <= r_sync2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_pause_press = r_press[0];
  assign w_step_press  = r_press[1];

  // ---------------------------------------------------------------------------
  // Run-control FSM with breakpoint.
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   r_pause;
  logic   r_step;
  logic   r_brk_hit;
  logic   r_brk_armed;
  logic   w_brk_match;
  logic   w_brk_take;
  logic   w_resume;
  logic   w_pause_nxt;
  logic   w_step_nxt;
  logic   w_brk_hit_nxt;
  logic   w_brk_armed_nxt;

  assign w_brk_match = BRK_EN & r_brk_armed & (cpuout_PC == BRK_PC);

  // State and registered control outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_RUN;
      r_pause     <= 1'b0;
      r_step      <= 1'b0;
      r_brk_hit   <= 1'b0;
      r_brk_armed <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_pause     <= w_pause_nxt;
      r_step      <= w_step_nxt;
      r_brk_hit   <= w_brk_hit_nxt;
      r_brk_armed <= w_brk_armed_nxt;
    end
  end

  // Next-state: breakpoint and pause share the RUN->HALT arc; in HALT a pause
  // press beats a same-cycle step press; STEPP always lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_brk_take  = 1'b0;
    w_resume    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_brk_match) begin
          w_state_nxt = ST_HALT;
          w_brk_take  = 1'b1;
        end else if (w_pause_press) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (w_pause_press) begin
          w_state_nxt = ST_RUN;
          w_resume    = 1'b1;
        end else if (w_step_press) begin
          w_state_nxt = ST_STEPP;
        end
      end
      ST_STEPP: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Output decode of the next state, plus breakpoint flag and re-arm logic.
  // Re-arming wins over the resume disarm, so resuming away from BRK_PC is armed.
  always_comb begin
    w_pause_nxt   = (w_state_nxt != ST_RUN);
    w_step_nxt    = (w_state_nxt == ST_STEPP);
    w_brk_hit_nxt = r_brk_hit;
    if (w_brk_take) begin
      w_brk_hit_nxt = 1'b1;
    end else if (w_resume) begin
      w_brk_hit_nxt = 1'b0;
    end
    w_brk_armed_nxt = r_brk_armed;
    if (!BRK_EN || (cpuout_PC != BRK_PC)) begin
      w_brk_armed_nxt = 1'b1;
    end else if (w_resume) begin
      w_brk_armed_nxt = 1'b0;
    end
  end

  assign PAUSE       = r_pause;
  assign STEP        = r_step;
  assign BRK_HIT     = r_brk_hit;
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Trace FIFO.
  // ---------------------------------------------------------------------------
  logic                r_mu_prev;
  logic [TRACE_AW-1:0] r_wr_ptr;
  logic [TRACE_AW-1:0] r_rd_ptr;
  logic [TRACE_AW:0]   r_cnt;
  logic                r_ovf;
  logic [7:0]          r_mem_addr [TRACE_DEPTH];
  logic [15:0]         r_mem_data [TRACE_DEPTH];
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;

  assign w_push  = cpuout_memupdate & ~r_mu_prev;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_FULL);
  assign w_pop   = TRACE_POP & ~w_empty;

  // Pointers, occupancy and sticky overflow. A push into a full FIFO without a
  // pop pushes the read pointer along so the oldest entry is lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mu_prev <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_mu_prev <= cpuout_memupdate;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop || (w_push && w_full)) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop && !w_full) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_push && !w_pop && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Entry storage; contents are only observed through the empty gate below.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= cpuout_memaddr;
      r_mem_data[r_wr_ptr] <= cpuout_memdata;
    end
  end

  assign TRACE_EMPTY     = w_empty;
  assign TRACE_ADDR      = w_empty ? 8'h00 : r_mem_addr[r_rd_ptr];
  assign TRACE_DATA      = w_empty ? 16'h0000 : r_mem_data[r_rd_ptr];
  assign TRACE_OVF       = r_ovf;
  assign o_dbg_trace_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a trace scoreboard queue.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  localparam int DEB = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        BTN_PAUSE = 1'b0;
  logic        BTN_STEP = 1'b0;
  logic        BRK_EN = 1'b0;
  logic [7:0]  BRK_PC = 8'h00;
  logic [7:0]  cpuout_PC = 8'h00;
  logic        cpuout_memupdate = 1'b0;
  logic [7:0]  cpuout_memaddr = 8'h00;
  logic [15:0] cpuout_memdata = 16'h0000;
  logic        TRACE_POP = 1'b0;
  logic        PAUSE;
  logic        STEP;
  logic        BRK_HIT;
  logic        TRACE_EMPTY;
  logic [7:0]  TRACE_ADDR;
  logic [15:0] TRACE_DATA;
  logic        TRACE_OVF;
  logic [1:0]  o_dbg_state;
  logic [3:0]  o_dbg_trace_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          steps;
  logic [23:0] exp_q[$];
  logic        exp_ovf = 1'b0;
  logic [23:0] dropped;

  cpu_run_ctrl #(
    .DEB_CYCLES(DEB), .DEB_W(3), .TRACE_DEPTH(8), .TRACE_AW(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_PAUSE(BTN_PAUSE), .BTN_STEP(BTN_STEP),
    .BRK_EN(BRK_EN), .BRK_PC(BRK_PC), .cpuout_PC(cpuout_PC),
    .cpuout_memupdate(cpuout_memupdate), .cpuout_memaddr(cpuout_memaddr),
    .cpuout_memdata(cpuout_memdata), .TRACE_POP(TRACE_POP),
    .PAUSE(PAUSE), .STEP(STEP), .BRK_HIT(BRK_HIT), .TRACE_EMPTY(TRACE_EMPTY),
    .TRACE_ADDR(TRACE_ADDR), .TRACE_DATA(TRACE_DATA), .TRACE_OVF(TRACE_OVF),
    .o_dbg_state(o_dbg_state), .o_dbg_trace_cnt(o_dbg_trace_cnt)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pause"}, 32'(PAUSE), 0);
    chk({tag, "_step"}, 32'(STEP), 0);
    chk({tag, "_brkhit"}, 32'(BRK_HIT), 0);
    chk({tag, "_empty"}, 32'(TRACE_EMPTY), 1);
    chk({tag, "_addr"}, 32'(TRACE_ADDR), 0);
    chk({tag, "_data"}, 32'(TRACE_DATA), 0);
    chk({tag, "_ovf"}, 32'(TRACE_OVF), 0);
    chk({tag, "_state"}, 32'(o_dbg_state), 0);
    chk({tag, "_cnt"}, 32'(o_dbg_trace_cnt), 0);
  endtask

  // driver: hold buttons, count STEP-high cycles through hold and settle
  task automatic hold_btn(input bit p, input bit s, input int cycles, output int n_step);
    n_step = 0;
    BTN_PAUSE = p;
    BTN_STEP  = s;
    for (int i = 0; i < cycles + 8; i++) begin
      if (i == cycles) begin
        BTN_PAUSE = 1'b0;
        BTN_STEP  = 1'b0;
      end
      tick(1);
      if (STEP) begin
        n_step++;
        chk("step_while_paused", 32'(PAUSE), 1);
      end
    end
  endtask

  // scoreboard model of the trace FIFO
  task automatic model_push(input logic [23:0] e);
    if (exp_q.size() == 8) begin
      dropped = exp_q.pop_front();
      exp_ovf = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk_head(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 32'(TRACE_EMPTY), 1);
      chk({tag, "_addr0"}, 32'(TRACE_ADDR), 0);
    end else begin
      chk({tag, "_nonempty"}, 32'(TRACE_EMPTY), 0);
      chk({tag, "_addr"}, 32'(TRACE_ADDR), 32'(exp_q[0][23:16]));
      chk({tag, "_data"}, 32'(TRACE_DATA), 32'(exp_q[0][15:0]));
    end
  endtask

  task automatic trace_push(input logic [7:0] a, input logic [15:0] d, input int hold);
    cpuout_memaddr   = a;
    cpuout_memdata   = d;
    cpuout_memupdate = 1'b1;
    model_push({a, d});
    tick(1);
    chk_head("push_head");
    chk("push_ovf", 32'(TRACE_OVF), 32'(exp_ovf));
    if (hold > 1) tick(hold - 1);
    cpuout_memupdate = 1'b0;
    tick(1);
  endtask

  task automatic trace_pop();
    chk_head("pop_head");
    TRACE_POP = 1'b1;
    if (exp_q.size() > 0) dropped = exp_q.pop_front();
    tick(1);
    TRACE_POP = 1'b0;
  endtask

  task automatic trace_push_pop(input logic [7:0] a, input logic [15:0] d);
    chk_head("pp_before");
    cpuout_memaddr   = a;
    cpuout_memdata   = d;
    cpuout_memupdate = 1'b1;
    TRACE_POP        = 1'b1;
    if (exp_q.size() > 0) dropped = exp_q.pop_front();
    model_push({a, d});
    tick(1);
    cpuout_memupdate = 1'b0;
    TRACE_POP        = 1'b0;
    chk_head("pp_after");
    chk("pp_ovf", 32'(TRACE_OVF), 32'(exp_ovf));
    tick(1);
  endtask

  initial begin
    // reset
    tick(3);
    chk_reset("rst_hold");
    RST_N = 1'b1;
    tick(1);
    chk_reset("rst_rel");

    // short glitches never reach the debounce threshold
    repeat (6) begin
      BTN_PAUSE = 1'b1;
      tick($urandom_range(1, DEB - 1));
      BTN_PAUSE = 1'b0;
      tick($urandom_range(1, 2));
      chk("glitch_pause", 32'(PAUSE), 0);
    end
    tick(8);
    chk("glitch_settle", 32'(PAUSE), 0);

    // held press: PAUSE rises 2 + DEB + 1 cycles after the button
    BTN_PAUSE = 1'b1;
    tick(2 + DEB);
    chk("pause_lat_early", 32'(PAUSE), 0);
    tick(1);
    chk("pause_lat", 32'(PAUSE), 1);
    chk("pause_state", 32'(o_dbg_state), 1);
    tick(3);
    BTN_PAUSE = 1'b0;
    tick(10);
    chk("pause_release", 32'(PAUSE), 1);

    // single step: one pulse per press, held or not
    hold_btn(1'b0, 1'b1, 14, steps);
    chk("step_once", 32'(steps), 1);
    chk("step_paused", 32'(PAUSE), 1);
    hold_btn(1'b0, 1'b1, 14, steps);
    chk("step_repress", 32'(steps), 1);
    chk("step_state", 32'(o_dbg_state), 1);

    // resume
    hold_btn(1'b1, 1'b0, 10, steps);
    chk("resume_pause", 32'(PAUSE), 0);
    chk("resume_nostep", 32'(steps), 0);

    // breakpoint
    BRK_EN = 1'b1;
    BRK_PC = 8'h10;
    for (int pc = 12; pc < 16; pc++) begin
      cpuout_PC = 8'(pc);
      tick(1);
      chk("brk_pre", 32'(PAUSE), 0);
    end
    cpuout_PC = 8'h10;
    tick(1);
    chk("brk_halt", 32'(PAUSE), 1);
    chk("brk_hit", 32'(BRK_HIT), 1);
    hold_btn(1'b1, 1'b0, 10, steps);
    chk("brk_resume", 32'(PAUSE), 0);
    chk("brk_hit_clr", 32'(BRK_HIT), 0);
    tick(5);
    chk("brk_no_retrig", 32'(PAUSE), 0);
    cpuout_PC = 8'h11;
    tick(1);
    chk("brk_away", 32'(PAUSE), 0);
    cpuout_PC = 8'h10;
    tick(1);
    chk("brk_rearm", 32'(PAUSE), 1);
    chk("brk_rearm_hit", 32'(BRK_HIT), 1);

    // pause and step pressed together in HALT: pause wins
    hold_btn(1'b1, 1'b1, 10, steps);
    chk("both_nostep", 32'(steps), 0);
    chk("both_pause", 32'(PAUSE), 0);
    chk("both_brkhit", 32'(BRK_HIT), 0);
    BRK_EN = 1'b0;

    // trace: halt, then 10 writes (one held high several cycles while paused)
    hold_btn(1'b1, 1'b0, 10, steps);
    chk("trace_paused", 32'(PAUSE), 1);
    for (int i = 0; i < 10; i++) begin
      trace_push(8'(i), 16'($urandom_range(0, 65535)), (i == 3) ? 4 : 1);
    end
    chk("ovf_set", 32'(TRACE_OVF), 1);
    chk("ovf_cnt", 32'(o_dbg_trace_cnt), 8);
    chk("ovf_head", 32'(TRACE_ADDR), 2);
    repeat (9) trace_pop();
    chk("drain_cnt", 32'(o_dbg_trace_cnt), 0);
    trace_push_pop(8'haa, 16'h1234);
    chk("pp_empty_cnt", 32'(o_dbg_trace_cnt), 1);
    trace_pop();
    chk_head("after_pp_pop");

    // fresh reset, fill, push+pop while full
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(1);
    chk_reset("rst2");
    for (int i = 0; i < 8; i++) begin
      trace_push(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 1);
    end
    chk("full_cnt", 32'(o_dbg_trace_cnt), 8);
    trace_push_pop(8'h5c, 16'hbeef);
    chk("full_pp_cnt", 32'(o_dbg_trace_cnt), 8);
    chk("full_pp_ovf", 32'(TRACE_OVF), 0);
    repeat (2) trace_pop();

    // asynchronous reset mid-debounce with trace entries present
    BTN_PAUSE = 1'b1;
    tick(3);
    #2;
    RST_N = 1'b0;
    BTN_PAUSE = 1'b0;
    #1;
    chk_reset("rst_async");
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(1);
    RST_N = 1'b1;
    tick(12);
    chk("post_rst_pause", 32'(PAUSE), 0);
    chk("post_rst_step", 32'(STEP), 0);
    chk_head("post_rst_head");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
